// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin arbiter granting one shared countdown timer to CHANNELS requesters
module timer_scheduler #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS-1:0]       req_i,
    input  logic [CHANNELS*WIDTH-1:0] count_i,
    output logic [CHANNELS-1:0]       grant_o,
    output logic [CHANNELS-1:0]       expire_o,
    output logic                      busy_o
);

    localparam int PW = $clog2(CHANNELS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Declaration initialisers give the reset values from power-up.
    state_t              r_state = IDLE;
    logic [WIDTH-1:0]    r_count = '0;
    logic [CHANNELS-1:0] r_grant = '0;
    logic [PW-1:0]       r_ptr   = PW'(CHANNELS - 1);

    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [WIDTH-1:0]    w_win_count;
    logic [CHANNELS-1:0] w_win_onehot;
    logic                w_req_own;

    // Search ascends from the channel after the last grant, wrapping once.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % CHANNELS;
            if (!w_found && req_i[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_win_count  = count_i[int'(w_win)*WIDTH +: WIDTH];
    assign w_win_onehot = CHANNELS'(1) << w_win;
    assign w_req_own    = |(req_i & r_grant);

    // A dropped request suppresses the pulse even when the counter is at zero.
    assign expire_o = (r_state == RUN && r_count == '0 && w_req_own) ? r_grant : '0;
    assign grant_o  = r_grant;
    assign busy_o   = (r_state == RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_grant <= '0;
            r_ptr   <= PW'(CHANNELS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_count <= w_win_count;
                        r_grant <= w_win_onehot;
                        r_ptr   <= w_win;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_req_own || r_count == '0) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed vector bench for timer_scheduler
module tb_timer_scheduler;

    localparam int W = 8;
    localparam int C = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [C-1:0]     req;
    logic [C*W-1:0]   cnt;
    logic [C-1:0]     grant;
    logic [C-1:0]     expire;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    timer_scheduler #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .count_i  (cnt),
        .grant_o  (grant),
        .expire_o (expire),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [C-1:0] req;
        logic [31:0]  cnt;
        logic [C-1:0] grant;
        logic [C-1:0] expire;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [C-1:0] q, input logic [31:0] c,
                       input logic [C-1:0] g, input logic [C-1:0] e, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.cnt = c; v.grant = g; v.expire = e; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Structural properties watched on every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        n_checks++;
        if (!$onehot0(grant) || !$onehot0(expire) || ((expire & ~grant) != '0)
            || (busy != (grant != '0))) begin
            n_fail++;
            $display("FAIL invariant: grant %b expire %b busy %b", grant, expire, busy);
        end
    end

    int n;

    initial begin
        // Single channel 0, count 5; count_i changed after grant has no effect.
        add(1, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0001, 32'h05, 4'b0000, 4'b0000, 0);
        add(0, 4'b0001, 32'h05, 4'b0001, 4'b0000, 1);
        add(0, 4'b0001, 32'hFF, 4'b0001, 4'b0000, 1);
        add(0, 4'b0001, 32'hFF, 4'b0001, 4'b0000, 1);
        add(0, 4'b0001, 32'hFF, 4'b0001, 4'b0000, 1);
        add(0, 4'b0001, 32'hFF, 4'b0001, 4'b0000, 1);
        add(0, 4'b0001, 32'hFF, 4'b0001, 4'b0001, 1);
        add(0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        // Zero count on channel 1.
        add(0, 4'b0010, 32'h0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0010, 32'h0, 4'b0010, 4'b0010, 1);
        add(0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        // Fairness, all counts 2, order 0,1,2,3,0.
        add(1, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 32'h02020202, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 5; k++) begin
            logic [C-1:0] g;
            g = 4'b0001 << (k % 4);
            add(0, 4'b1111, 32'h02020202, g, 4'b0000, 1);
            add(0, 4'b1111, 32'h02020202, g, 4'b0000, 1);
            add(0, 4'b1111, 32'h02020202, g, g, 1);
            if (k < 4) add(0, 4'b1111, 32'h02020202, 4'b0000, 4'b0000, 0);
        end
        add(0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 0);
        // Cancel channel 2 after 3 cycles; next arbitration starts at channel 3.
        add(0, 4'b0100, 32'h050A0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b0100, 32'h050A0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b0100, 32'h050A0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b0100, 32'h050A0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b0000, 32'h050A0000, 4'b0100, 4'b0000, 1);
        add(0, 4'b1011, 32'h050A0000, 4'b0000, 4'b0000, 0);
        add(0, 4'b1011, 32'h050A0000, 4'b1000, 4'b0000, 1);
        add(0, 4'b0000, 32'h050A0000, 4'b1000, 4'b0000, 1);
        // Reset mid-run on channel 1, then channel 0 priority restored.
        add(0, 4'b0010, 32'h00000800, 4'b0000, 4'b0000, 0);
        add(0, 4'b0010, 32'h00000800, 4'b0010, 4'b0000, 1);
        add(0, 4'b0010, 32'h00000800, 4'b0010, 4'b0000, 1);
        add(0, 4'b0010, 32'h00000800, 4'b0010, 4'b0000, 1);
        add(1, 4'b0010, 32'h00000800, 4'b0010, 4'b0000, 1);
        add(0, 4'b1010, 32'h00000800, 4'b0000, 4'b0000, 0);
        add(0, 4'b1010, 32'h00000800, 4'b0010, 4'b0000, 1);
        add(1, 4'b0000, 32'h0, 4'b0010, 4'b0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            cnt = vecs[i].cnt;
            #2;
            check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("vec%0d expire", i), 32'(expire), 32'(vecs[i].expire));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            @(posedge clk);
            #1;
        end

        // Maximum count: 255 decrement cycles between grant and expiry.
        rst = 0; req = 4'b0001; cnt = 32'hFF;
        @(posedge clk); #1;
        check("max grant", 32'(grant), 32'h1);
        cnt = 32'h0;
        n = 0;
        while (expire == '0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("max latency", 32'(n), 32'd255);
        req = 4'b0000;
        @(posedge clk); #1;
        check("max release", 32'(grant), 32'h0);

        // Cancel coinciding with a zero counter: no pulse.
        req = 4'b0100; cnt = 32'h0;
        @(posedge clk); #1;
        check("coincide grant", 32'(grant), 32'h4);
        req = 4'b0000;
        #1;
        check("coincide expire", 32'(expire), 32'h0);
        @(posedge clk); #1;
        check("coincide release", 32'(grant), 32'h0);

        // Non-granted request during RUN is ignored.
        req = 4'b0001; cnt = 32'h03;
        @(posedge clk); #1;
        req = 4'b0011;
        @(posedge clk); #1;
        check("no preempt", 32'(grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
